// File: rtl/img_mem_if.sv
// img_mem_if: port bundle for img_mem_stream (write port, two read ports, clear/export control, export stream, error flag)
interface img_mem_if #(
  parameter int AW = 4,
  parameter int DATA_W = 32
);
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [AW-1:0]     rd_addr1;
  logic [AW-1:0]     rd_addr2;
  logic [DATA_W-1:0] rd_data1;
  logic [DATA_W-1:0] rd_data2;
  logic              clr;
  logic              start;
  logic              busy;
  logic              exp_valid;
  logic              exp_ready;
  logic [DATA_W-1:0] exp_data;
  logic              exp_last;
  logic              oob_err;
  modport master (
    output wr_en, wr_addr, wr_data, rd_addr1, rd_addr2, clr, start, exp_ready,
    input  rd_data1, rd_data2, busy, exp_valid, exp_data, exp_last, oob_err
  );
  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr1, rd_addr2, clr, start, exp_ready,
    output rd_data1, rd_data2, busy, exp_valid, exp_data, exp_last, oob_err
  );
endinterface

// File: rtl/img_mem_stream.sv
// img_mem_stream: IMG_ROWS x IMG_COLS word store with one write port, two combinational read ports,
// a one-word-per-cycle clear sweep and a valid/ready raster-order export stream.
// Ports: clk, rst (async, active-high), bus (img_mem_if.slave): wr_en/wr_addr/wr_data, rd_addr1/2 -> rd_data1/2,
// clr, start, busy, exp_valid/exp_ready/exp_data/exp_last, oob_err.
// Option: define IMG_MEM_OOB_ERR_EN to enable the sticky out-of-range access flag (otherwise oob_err = 0).
module img_mem_stream #(
  parameter int IMG_ROWS = 4,
  parameter int IMG_COLS = 4,
  parameter int DATA_W = 32,
  parameter logic [DATA_W-1:0] FILL = '1
) (
  input logic clk,
  input logic rst,
  img_mem_if.slave bus
);
  localparam int DEPTH = IMG_ROWS * IMG_COLS;
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  typedef enum logic [1:0] {IDLE, CLEAR, EXPORT} state_t;
  state_t state, state_n;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] exp_q;
  logic [AW-1:0] idx, idx_n;
  logic clr_acc, start_acc, hs, last;
  function automatic logic in_range(input logic [AW-1:0] a);
    return {1'b0, a} < (AW+1)'(DEPTH);
  endfunction
  always_comb begin
    last = state == EXPORT && idx == AW'(DEPTH - 1);
    clr_acc = state == IDLE && bus.clr;
    start_acc = state == IDLE && bus.start && !bus.clr;
    hs = state == EXPORT && bus.exp_ready;
    idx_n = idx + 1'b1;
    state_n = clr_acc ? CLEAR :
              start_acc ? EXPORT :
              ((state == CLEAR && idx == AW'(DEPTH - 1)) || (hs && last)) ? IDLE : state;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  // Export words are snapshotted from pre-edge contents when first presented, so a
  // write landing on the word being loaded or already shown does not reach the stream.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= FILL;
      idx <= '0;
      exp_q <= '0;
    end else begin
      if (state == CLEAR) mem[idx] <= FILL;
      else if (bus.wr_en && in_range(bus.wr_addr)) mem[bus.wr_addr] <= bus.wr_data;
      idx <= (clr_acc || start_acc) ? '0 : (state == CLEAR || hs) ? idx_n : idx;
      if (start_acc) exp_q <= mem[0];
      else if (hs && !last) exp_q <= mem[idx_n];
    end
  assign bus.rd_data1 = in_range(bus.rd_addr1) ? mem[bus.rd_addr1] : '0;
  assign bus.rd_data2 = in_range(bus.rd_addr2) ? mem[bus.rd_addr2] : '0;
  assign bus.busy = state != IDLE;
  assign bus.exp_valid = state == EXPORT;
  assign bus.exp_last = last;
  assign bus.exp_data = exp_q;
`ifdef IMG_MEM_OOB_ERR_EN
  logic oob_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) oob_q <= 1'b0;
    else oob_q <= (oob_q && !clr_acc) || (bus.wr_en && !in_range(bus.wr_addr)) ||
                  !in_range(bus.rd_addr1) || !in_range(bus.rd_addr2);
  assign bus.oob_err = oob_q;
`else
  assign bus.oob_err = 1'b0;
`endif
endmodule
